// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, byte-mask constants and access-legality helpers for
// the data-memory arbiter.
//   size_e  : requested access size (byte / half / word / illegal)
//   state_e : arbiter FSM state, also driven out on the debug port
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic [3:0] BMASK_WORD = 4'b1111;
   localparam logic [3:0] BMASK_HALF = 4'b0011;
   localparam logic [3:0] BMASK_BYTE = 4'b0001;

   // The memory shifts the mask to the addressed lane, so the mask is always
   // right-aligned here. An illegal size never writes, so its mask is moot.
   function automatic logic [3:0] size_bmask(input size_e sz);
      case (sz)
         SZ_BYTE: size_bmask = BMASK_BYTE;
         SZ_HALF: size_bmask = BMASK_HALF;
         default: size_bmask = BMASK_WORD;
      endcase
   endfunction

   // Illegal size, or a half/word access that is not naturally aligned.
   function automatic logic access_err(input size_e sz, input logic [1:0] lsb);
      case (sz)
         SZ_BYTE: access_err = 1'b0;
         SZ_HALF: access_err = lsb[0];
         SZ_WORD: access_err = |lsb;
         default: access_err = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first asserted request at or after a
// rotating pointer.
//   i_req   : request vector
//   i_ptr   : index of the highest-priority port this round
//   o_grant : one-hot grant (all zero when no request)
//   o_idx   : index of the granted port
//   o_any   : at least one request present
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   logic [IDX_W-1:0] k;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      k       = '0;
      // Walk ports starting at the pointer; the first hit wins.
      for (int i = 0; i < NUM_REQ; i++) begin
         k = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
         if (!o_any && i_req[k]) begin
            o_any      = 1'b1;
            o_grant[k] = 1'b1;
            o_idx      = k;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between NUM_REQ requesters
// (port 0 = core LSU, port 1 = loader/debug), one access in flight.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_req_* / o_req_ready     : per-port request channel
//   o_rsp_valid / i_rsp_ready : per-port response channel (only the owner sees valid)
//   o_rsp_rdata / o_rsp_err   : extended load data, misaligned/illegal flag
//   o_mem_*  / i_mem_rdata    : data memory interface (read data lane-shifted to bit 0)
//   o_dbg_state               : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Requesters hold every request field stable while valid && !ready;
// o_rsp_valid stays high with stable data until the owner returns i_rsp_ready.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 32
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [NUM_REQ-1:0]              i_req_valid,
   output logic [NUM_REQ-1:0]              o_req_ready,
   input  logic [NUM_REQ-1:0]              i_req_we,
   input  logic [NUM_REQ-1:0][1:0]         i_req_size,
   input  logic [NUM_REQ-1:0]              i_req_signed,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  i_req_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  i_req_wdata,
   output logic [NUM_REQ-1:0]              o_rsp_valid,
   input  logic [NUM_REQ-1:0]              i_rsp_ready,
   output logic [DATA_W-1:0]               o_rsp_rdata,
   output logic                            o_rsp_err,
   output logic [ADDR_W-1:0]               o_mem_addr,
   output logic [DATA_W-1:0]               o_mem_wdata,
   output logic [3:0]                      o_mem_bmask,
   output logic                            o_mem_wren,
   input  logic [DATA_W-1:0]               i_mem_rdata,
   output state_e                          o_dbg_state
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e            state, state_nxt;
   logic [IDX_W-1:0]  rr_ptr, owner, gnt_idx;
   logic [NUM_REQ-1:0] gnt_oh;
   logic              gnt_any;
   logic              lat_we, lat_signed, lat_err;
   size_e             lat_size, req_size;
   logic [DATA_W-1:0] rdata_ext;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .i_req   (i_req_valid),
      .i_ptr   (rr_ptr),
      .o_grant (gnt_oh),
      .o_idx   (gnt_idx),
      .o_any   (gnt_any)
   );

   assign req_size    = size_e'(i_req_size[gnt_idx]);
   assign o_dbg_state = state;

   // Next state and all handshake/strobe outputs. Making wren a pure decode of
   // the state register lets an async reset kill a store mid-access at once.
   always_comb begin
      state_nxt   = state;
      o_req_ready = '0;
      o_rsp_valid = '0;
      o_mem_wren  = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_any) begin
               o_req_ready = gnt_oh;
               state_nxt   = ACCESS;
            end
         end
         ACCESS: begin
            o_mem_wren = lat_we && !lat_err;
            state_nxt  = RESP;
         end
         RESP: begin
            o_rsp_valid[owner] = 1'b1;
            if (i_rsp_ready[owner]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Zero/sign extension of the lane-shifted read data.
   always_comb begin
      rdata_ext = i_mem_rdata;
      case (lat_size)
         SZ_BYTE: rdata_ext = {{(DATA_W-8){lat_signed & i_mem_rdata[7]}}, i_mem_rdata[7:0]};
         SZ_HALF: rdata_ext = {{(DATA_W-16){lat_signed & i_mem_rdata[15]}}, i_mem_rdata[15:0]};
         default: rdata_ext = i_mem_rdata;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         owner       <= '0;
         lat_we      <= 1'b0;
         lat_signed  <= 1'b0;
         lat_err     <= 1'b0;
         lat_size    <= SZ_BYTE;
         o_rsp_rdata <= '0;
         o_rsp_err   <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_bmask <= BMASK_WORD;
      end else begin
         state <= state_nxt;
         // The memory address/mask/data registers double as the request latch,
         // so they hold their last values outside of a grant.
         if (state == IDLE && gnt_any) begin
            owner       <= gnt_idx;
            rr_ptr      <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            lat_we      <= i_req_we[gnt_idx];
            lat_signed  <= i_req_signed[gnt_idx];
            lat_size    <= req_size;
            lat_err     <= access_err(req_size, i_req_addr[gnt_idx][1:0]);
            o_mem_addr  <= i_req_addr[gnt_idx];
            o_mem_wdata <= i_req_wdata[gnt_idx];
            o_mem_bmask <= size_bmask(req_size);
         end
         if (state == ACCESS) begin
            o_rsp_err   <= lat_err;
            o_rsp_rdata <= (lat_err || lat_we) ? '0 : rdata_ext;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a byte-array memory
// model that returns read data shifted so the addressed byte sits at bit 0.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 11;
   localparam int DATA_W  = 32;

   logic                           i_clk = 1'b0;
   logic                           i_rst_n = 1'b0;
   logic [NUM_REQ-1:0]             i_req_valid;
   logic [NUM_REQ-1:0]             o_req_ready;
   logic [NUM_REQ-1:0]             i_req_we;
   logic [NUM_REQ-1:0][1:0]        i_req_size;
   logic [NUM_REQ-1:0]             i_req_signed;
   logic [NUM_REQ-1:0][ADDR_W-1:0] i_req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] i_req_wdata;
   logic [NUM_REQ-1:0]             o_rsp_valid;
   logic [NUM_REQ-1:0]             i_rsp_ready;
   logic [DATA_W-1:0]              o_rsp_rdata;
   logic                           o_rsp_err;
   logic [ADDR_W-1:0]              o_mem_addr;
   logic [DATA_W-1:0]              o_mem_wdata;
   logic [3:0]                     o_mem_bmask;
   logic                           o_mem_wren;
   logic [DATA_W-1:0]              i_mem_rdata;
   state_e                         o_dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int wren_cnt = 0;
   logic [DATA_W:0] exp_q[$];   // {err, rdata}

   dmem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_we     (i_req_we),
      .i_req_size   (i_req_size),
      .i_req_signed (i_req_signed),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .o_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .o_rsp_rdata  (o_rsp_rdata),
      .o_rsp_err    (o_rsp_err),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_mem_bmask  (o_mem_bmask),
      .o_mem_wren   (o_mem_wren),
      .i_mem_rdata  (i_mem_rdata),
      .o_dbg_state  (o_dbg_state)
   );

   // ---------------- clock ----------------
   always #5 i_clk = ~i_clk;

   // ---------------- memory model ----------------
   logic [7:0]        mem [0:2047];
   logic [ADDR_W-1:0] ma1, ma2, ma3;
   assign ma1 = o_mem_addr + 11'd1;
   assign ma2 = o_mem_addr + 11'd2;
   assign ma3 = o_mem_addr + 11'd3;
   assign i_mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[o_mem_addr]};

   always @(posedge i_clk) begin
      if (o_mem_wren)
         for (int j = 0; j < 4; j++)
            if (o_mem_bmask[j]) mem[o_mem_addr + ADDR_W'(j)] <= o_mem_wdata[8*j +: 8];
   end

   always @(negedge i_clk) if (o_mem_wren) wren_cnt <= wren_cnt + 1;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input int p, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [10:0] ad, input logic [31:0] wd);
      i_req_we[p]     = we;
      i_req_size[p]   = sz;
      i_req_signed[p] = sg;
      i_req_addr[p]   = ad;
      i_req_wdata[p]  = wd;
      i_req_valid[p]  = 1'b1;
   endtask

   // Returns #1 after the handshake edge; valid is left for the caller.
   task automatic wait_ready(input int p);
      int n = 0;
      #1;
      while (!o_req_ready[p] && n < 20) begin
         @(negedge i_clk); #1;
         n++;
      end
      check("req_ready", o_req_ready[p], 1'b1);
      @(posedge i_clk); #1;
   endtask

   task automatic wait_rsp(input int p, output logic [DATA_W-1:0] rd, output logic er);
      int n = 0;
      logic [NUM_REQ-1:0] exp_v;
      exp_v = 2'b01 << p;
      do begin
         @(negedge i_clk); #1;
         n++;
      end while (!o_rsp_valid[p] && n < 20);
      check("rsp_valid_owner", o_rsp_valid, exp_v);
      rd = o_rsp_rdata;
      er = o_rsp_err;
   endtask

   task automatic txn(input int p, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [10:0] ad, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eer, input int ewr, input string tag);
      int w0;
      logic [DATA_W-1:0] rd;
      logic er;
      logic [DATA_W:0] e;
      exp_q.push_back({eer, erd});
      w0 = wren_cnt;
      drive(p, we, sz, sg, ad, wd);
      wait_ready(p);
      i_req_valid[p] = 1'b0;
      wait_rsp(p, rd, er);
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rd, e[DATA_W-1:0]);
      check({tag, "_err"}, er, e[DATA_W]);
      check({tag, "_wren_cycles"}, wren_cnt - w0, ewr);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, o_req_ready, 0);
      check({tag, "_rsp_valid"}, o_rsp_valid, 0);
      check({tag, "_rsp_rdata"}, o_rsp_rdata, 0);
      check({tag, "_rsp_err"}, o_rsp_err, 0);
      check({tag, "_mem_addr"}, o_mem_addr, 0);
      check({tag, "_mem_wdata"}, o_mem_wdata, 0);
      check({tag, "_mem_bmask"}, o_mem_bmask, 4'b1111);
      check({tag, "_mem_wren"}, o_mem_wren, 0);
      check({tag, "_state"}, o_dbg_state, IDLE);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [DATA_W-1:0] rd;
      logic er;
      logic [NUM_REQ-1:0] exp_v;
      int ng, nr, last_g, w0;

      i_req_valid  = '0;
      i_req_we     = '0;
      i_req_size   = '0;
      i_req_signed = '0;
      i_req_addr   = '0;
      i_req_wdata  = '0;
      i_rsp_ready  = '1;
      i_rst_n      = 1'b0;

      repeat (3) @(negedge i_clk);
      check_reset_outputs("reset");
      i_rst_n = 1'b1;
      @(negedge i_clk); #1;

      // 1: word store then load
      txn(0, 1'b1, SZ_WORD, 1'b0, 11'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1, "t1_st");
      txn(0, 1'b0, SZ_WORD, 1'b0, 11'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0, "t1_ld");

      // 2: byte store and extension
      txn(0, 1'b1, SZ_BYTE, 1'b0, 11'h013, 32'h00000080, 32'h0, 1'b0, 1, "t2_stb");
      txn(0, 1'b0, SZ_BYTE, 1'b1, 11'h013, 32'h0, 32'hFFFFFF80, 1'b0, 0, "t2_ldb_s");
      txn(0, 1'b0, SZ_BYTE, 1'b0, 11'h013, 32'h0, 32'h00000080, 1'b0, 0, "t2_ldb_u");
      txn(0, 1'b0, SZ_WORD, 1'b0, 11'h010, 32'h0, 32'h80ADBEEF, 1'b0, 0, "t2_ldw");
      txn(0, 1'b0, SZ_HALF, 1'b1, 11'h012, 32'h0, 32'hFFFF80AD, 1'b0, 0, "t2_ldh_s");
      txn(0, 1'b0, SZ_HALF, 1'b0, 11'h012, 32'h0, 32'h000080AD, 1'b0, 0, "t2_ldh_u");
      // port 1 access also leaves the pointer at port 0
      txn(1, 1'b1, SZ_WORD, 1'b0, 11'h020, 32'hCAFEF00D, 32'h0, 1'b0, 1, "t2_p1_st");

      // 3: both ports valid continuously, strict alternation
      drive(0, 1'b0, SZ_WORD, 1'b0, 11'h010, 32'h0);
      drive(1, 1'b0, SZ_WORD, 1'b0, 11'h020, 32'h0);
      ng = 0; nr = 0; last_g = 0;
      for (int c = 0; c < 60 && nr < 6; c++) begin
         @(negedge i_clk); #1;
         if (o_rsp_valid != 0) begin
            exp_v = 2'b01 << last_g;
            check("t3_rsp_owner", o_rsp_valid, exp_v);
            check("t3_rsp_rdata", o_rsp_rdata, (last_g == 0) ? 32'h80ADBEEF : 32'hCAFEF00D);
            nr++;
         end
         if (o_req_ready != 0) begin
            exp_v = 2'b01 << (ng % 2);
            check("t3_grant", o_req_ready, exp_v);
            last_g = ng % 2;
            ng++;
            if (ng == 6) begin
               @(posedge i_clk); #1;
               i_req_valid = '0;
            end
         end
      end
      check("t3_responses", nr, 6);

      // 4: misaligned and illegal accesses
      txn(0, 1'b0, SZ_HALF, 1'b0, 11'h011, 32'h0, 32'h0, 1'b1, 0, "t4_ldh_mis");
      txn(1, 1'b1, SZ_WORD, 1'b0, 11'h012, 32'h12345678, 32'h0, 1'b1, 0, "t4_stw_mis");
      txn(0, 1'b0, SZ_ILL, 1'b0, 11'h010, 32'h0, 32'h0, 1'b1, 0, "t4_ill");
      txn(0, 1'b0, SZ_WORD, 1'b0, 11'h010, 32'h0, 32'h80ADBEEF, 1'b0, 0, "t4_ldw");

      // 5: response back-pressure
      @(negedge i_clk); #1;
      i_rsp_ready = '0;
      drive(0, 1'b0, SZ_WORD, 1'b0, 11'h020, 32'h0);
      wait_ready(0);
      i_req_valid[0] = 1'b0;
      drive(1, 1'b0, SZ_WORD, 1'b0, 11'h010, 32'h0);
      wait_rsp(0, rd, er);
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk); #1;
         check("t5_hold_valid", o_rsp_valid, 2'b01);
         check("t5_no_ready", o_req_ready, 2'b00);
      end
      check("t5_rdata", o_rsp_rdata, 32'hCAFEF00D);
      i_rsp_ready = '1;
      @(negedge i_clk); #1;
      check("t5_idle", o_dbg_state, IDLE);
      check("t5_next_grant", o_req_ready, 2'b10);
      @(posedge i_clk); #1;
      i_req_valid[1] = 1'b0;
      wait_rsp(1, rd, er);
      check("t5_p1_rdata", rd, 32'h80ADBEEF);

      // 6: async reset during a store access
      txn(0, 1'b1, SZ_WORD, 1'b0, 11'h030, 32'h11223344, 32'h0, 1'b0, 1, "t6_pre");
      drive(0, 1'b1, SZ_WORD, 1'b0, 11'h030, 32'hAABBCCDD);
      wait_ready(0);
      i_req_valid[0] = 1'b0;
      check("t6_in_access", o_dbg_state, ACCESS);
      check("t6_wren_before", o_mem_wren, 1'b1);
      #1;
      w0 = wren_cnt;
      i_rst_n = 1'b0;
      #1;
      check_reset_outputs("t6_rst");
      @(posedge i_clk);
      @(negedge i_clk); #1;
      check("t6_no_rsp", o_rsp_valid, 0);
      check("t6_no_wren", wren_cnt - w0, 0);
      i_rst_n = 1'b1;
      // pointer back at port 0
      drive(0, 1'b0, SZ_WORD, 1'b0, 11'h030, 32'h0);
      drive(1, 1'b0, SZ_WORD, 1'b0, 11'h010, 32'h0);
      #1;
      check("t6_ptr_reset", o_req_ready, 2'b01);
      @(posedge i_clk); #1;
      i_req_valid[0] = 1'b0;
      wait_rsp(0, rd, er);
      check("t6_word_unchanged", rd, 32'h11223344);
      wait_ready(1);
      i_req_valid[1] = 1'b0;
      wait_rsp(1, rd, er);
      check("t6_p1_rdata", rd, 32'h80ADBEEF);

      repeat (2) @(negedge i_clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
